// File: rtl/galaga_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : galaga_pkg
//  Description : Shared types and default constants for the collision and
//                scoring block (game-state encoding, default game tuning).
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package galaga_pkg;

  // Game-state encoding shared by the FSM and anything observing it.
  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    FLASH = 2'd1,
    OVER  = 2'd2
  } game_state_t;

  // Default tuning values; module parameters default to these.
  localparam int LIVES_INIT_DEF   = 3;
  localparam int FLASH_FRAMES_DEF = 60;
  localparam int HIT_THRESH_DEF   = 4;
  localparam int SCORE_W_DEF      = 10;

endpackage : galaga_pkg
`default_nettype wire

// File: rtl/collision_score_if.sv
`default_nettype none
// ============================================================================
//  Module      : collision_score_if
//  Description : Bundle between the video generator / game logic and the
//                collision_score block.
//  Signals     : vsync, blank_b, rpixel, apixel, ast_at_bottom, start
//                  (video side -> scorer)
//                lives, score, hit_pulse, respawn_req, flash, freeze,
//                game_over (scorer -> movement logic / colour mux)
//  Modports    : master - video/game side, slave - collision_score
//  Revision    : 1.0 - initial release
// ============================================================================
interface collision_score_if #(
  parameter int SCORE_W = 10
);
  logic               vsync;
  logic               blank_b;
  logic               rpixel;
  logic               apixel;
  logic               ast_at_bottom;
  logic               start;
  logic [1:0]         lives;
  logic [SCORE_W-1:0] score;
  logic               hit_pulse;
  logic               respawn_req;
  logic               flash;
  logic               freeze;
  logic               game_over;

  modport master (
    output vsync, blank_b, rpixel, apixel, ast_at_bottom, start,
    input  lives, score, hit_pulse, respawn_req, flash, freeze, game_over
  );

  modport slave (
    input  vsync, blank_b, rpixel, apixel, ast_at_bottom, start,
    output lives, score, hit_pulse, respawn_req, flash, freeze, game_over
  );
endinterface : collision_score_if
`default_nettype wire

// File: rtl/collision_score_frame_overlap_counter.sv
`default_nettype none
// ============================================================================
//  Module      : frame_overlap_counter
//  Description : Detects the falling edge of vsync (one frame_tick per frame)
//                and counts rocket/asteroid overlap pixels in the visible
//                area, saturating at 255. The count is judged against
//                HIT_THRESH on frame_tick and cleared in the same cycle.
//  Ports       : clk, reset (async, active-high)
//                vsync_i, blank_b_i, rpixel_i, apixel_i - video inputs
//                clear_i      - drop the partial-frame count (game restart)
//                frame_tick_o - one-cycle frame boundary strobe
//                hit_frame_o  - count >= HIT_THRESH, valid with frame_tick_o
//  Revision    : 1.0 - initial release
// ============================================================================
module frame_overlap_counter #(
  parameter int HIT_THRESH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic vsync_i,
  input  logic blank_b_i,
  input  logic rpixel_i,
  input  logic apixel_i,
  input  logic clear_i,
  output logic frame_tick_o,
  output logic hit_frame_o
);

  logic       vsync_q;
  logic [7:0] overlap_cnt_q;
  logic       overlap_d;

  assign frame_tick_o = vsync_q & ~vsync_i;
  assign overlap_d    = blank_b_i & rpixel_i & apixel_i;
  assign hit_frame_o  = (overlap_cnt_q >= 8'(HIT_THRESH));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vsync_q       <= 1'b1;
      overlap_cnt_q <= 8'd0;
    end else begin
      vsync_q <= vsync_i;
      // The boundary cycle's own overlap is dropped: blank_b is low there.
      if (frame_tick_o || clear_i) begin
        overlap_cnt_q <= 8'd0;
      end else if (overlap_d && (overlap_cnt_q != 8'hFF)) begin
        overlap_cnt_q <= overlap_cnt_q + 8'd1;
      end
    end
  end

endmodule : frame_overlap_counter
`default_nettype wire

// File: rtl/collision_score.sv
`default_nettype none
// ============================================================================
//  Module      : collision_score
//  Description : Per-frame hit detection, lives / invulnerability / game-over
//                state machine and saturating score counter. All decisions
//                are registered and appear one clk after frame_tick.
//  Ports       : clk   - pixel clock
//                reset - asynchronous, active-high
//                bus   - collision_score_if.slave (video inputs, start,
//                        lives/score/hit_pulse/respawn_req/flash/freeze/
//                        game_over outputs)
//  Revision    : 1.0 - initial release
// ============================================================================
module collision_score
  import galaga_pkg::*;
#(
  parameter int LIVES_INIT   = LIVES_INIT_DEF,
  parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
  parameter int HIT_THRESH   = HIT_THRESH_DEF,
  parameter int SCORE_W      = SCORE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  collision_score_if.slave  bus
);

  // Blink uses bit 3 of the flash counter, so keep at least 4 bits.
  localparam int FC_W = ($clog2(FLASH_FRAMES) < 4) ? 4 : $clog2(FLASH_FRAMES);
  localparam logic [FC_W-1:0]    FLASH_LOAD = FC_W'(FLASH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
  localparam logic [1:0]         LIVES_LOAD = 2'(LIVES_INIT);

  game_state_t        state_q;
  logic [1:0]         lives_q;
  logic [SCORE_W-1:0] score_q;
  logic [SCORE_W-1:0] score_d;
  logic [FC_W-1:0]    flash_cnt_q;
  logic               hit_pulse_q;
  logic               respawn_req_q;
  logic               flash_q;
  logic               freeze_q;
  logic               game_over_q;

  logic               frame_tick;
  logic               hit_frame;
  logic               restart_d;

  // start is only honoured while the game is over.
  assign restart_d = (state_q == OVER) && bus.start;
  assign score_d   = (score_q == SCORE_MAX) ? score_q : score_q + SCORE_W'(1);

  frame_overlap_counter #(
    .HIT_THRESH (HIT_THRESH)
  ) u_overlap (
    .clk          (clk),
    .reset        (reset),
    .vsync_i      (bus.vsync),
    .blank_b_i    (bus.blank_b),
    .rpixel_i     (bus.rpixel),
    .apixel_i     (bus.apixel),
    .clear_i      (restart_d),
    .frame_tick_o (frame_tick),
    .hit_frame_o  (hit_frame)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= PLAY;
      lives_q       <= LIVES_LOAD;
      score_q       <= '0;
      flash_cnt_q   <= '0;
      hit_pulse_q   <= 1'b0;
      respawn_req_q <= 1'b0;
      flash_q       <= 1'b0;
      freeze_q      <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      hit_pulse_q   <= 1'b0;
      respawn_req_q <= 1'b0;
      case (state_q)
        PLAY: begin
          if (frame_tick) begin
            if (hit_frame) begin
              // A hit wins over scoring in the same frame.
              hit_pulse_q <= 1'b1;
              lives_q     <= lives_q - 2'd1;
              if (lives_q == 2'd1) begin
                state_q     <= OVER;
                freeze_q    <= 1'b1;
                game_over_q <= 1'b1;
              end else begin
                flash_cnt_q <= FLASH_LOAD;
                state_q     <= FLASH;
              end
            end else if (bus.ast_at_bottom) begin
              score_q <= score_d;
            end
          end
        end
        FLASH: begin
          if (frame_tick) begin
            if (flash_cnt_q == '0) begin
              state_q       <= PLAY;
              respawn_req_q <= 1'b1;
              flash_q       <= 1'b0;
            end else begin
              flash_q     <= flash_cnt_q[3];
              flash_cnt_q <= flash_cnt_q - FC_W'(1);
            end
          end
        end
        OVER: begin
          if (bus.start) begin
            lives_q     <= LIVES_LOAD;
            score_q     <= '0;
            state_q     <= PLAY;
            freeze_q    <= 1'b0;
            game_over_q <= 1'b0;
          end
        end
        default: begin
          state_q <= PLAY;
        end
      endcase
    end
  end

  assign bus.lives       = lives_q;
  assign bus.score       = score_q;
  assign bus.hit_pulse   = hit_pulse_q;
  assign bus.respawn_req = respawn_req_q;
  assign bus.flash       = flash_q;
  assign bus.freeze      = freeze_q;
  assign bus.game_over   = game_over_q;

endmodule : collision_score
`default_nettype wire

// File: tb/tb_collision_score.sv
`default_nettype none
// ============================================================================
//  Module      : tb_collision_score
//  Description : Self-checking bench for collision_score: table of single
//                frames plus hand-written FLASH, saturation, game-over,
//                restart and mid-FLASH reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_collision_score;

  logic clk;
  logic reset;
  int   n_total;
  int   n_pass;

  collision_score_if #(.SCORE_W(10)) bus ();

  collision_score #(
    .LIVES_INIT   (3),
    .FLASH_FRAMES (60),
    .HIT_THRESH   (4),
    .SCORE_W      (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int nov;
    bit bot;
    int exp_lives;
    int exp_score;
    bit exp_hit;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One frame: nov visible overlap pixels, one blanked overlap cycle that
  // must not count, then the vsync falling edge. p_hit/p_resp are sampled
  // just after the decision edge, q_hit/q_resp one clk later.
  task automatic do_frame(input int nov, input bit bot,
                          output bit p_hit, output bit q_hit,
                          output bit p_resp, output bit q_resp);
    bus.ast_at_bottom = bot;
    bus.blank_b = 1'b1;
    for (int i = 0; i < nov; i++) begin
      bus.rpixel = 1'b1; bus.apixel = 1'b1;
      tick();
    end
    bus.blank_b = 1'b0;
    tick();
    bus.rpixel = 1'b0; bus.apixel = 1'b0;
    bus.vsync = 1'b0;
    tick();
    p_hit  = bus.hit_pulse;
    p_resp = bus.respawn_req;
    bus.vsync = 1'b1;
    tick();
    q_hit  = bus.hit_pulse;
    q_resp = bus.respawn_req;
  endtask

  bit ph, qh, pr, qr;

  initial begin
    n_total = 0;
    n_pass  = 0;
    tbl[0] = '{nov: 3, bot: 1'b0, exp_lives: 3, exp_score: 0, exp_hit: 1'b0};
    tbl[1] = '{nov: 0, bot: 1'b1, exp_lives: 3, exp_score: 1, exp_hit: 1'b0};
    tbl[2] = '{nov: 2, bot: 1'b1, exp_lives: 3, exp_score: 2, exp_hit: 1'b0};
    tbl[3] = '{nov: 0, bot: 1'b1, exp_lives: 3, exp_score: 3, exp_hit: 1'b0};
    tbl[4] = '{nov: 3, bot: 1'b1, exp_lives: 3, exp_score: 4, exp_hit: 1'b0};
    tbl[5] = '{nov: 1, bot: 1'b1, exp_lives: 3, exp_score: 5, exp_hit: 1'b0};
    tbl[6] = '{nov: 4, bot: 1'b1, exp_lives: 2, exp_score: 5, exp_hit: 1'b1};

    reset = 1'b1;
    bus.vsync = 1'b1; bus.blank_b = 1'b0; bus.rpixel = 1'b0; bus.apixel = 1'b0;
    bus.ast_at_bottom = 1'b0; bus.start = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();

    chk("reset lives", bus.lives, 3);
    chk("reset score", bus.score, 0);
    chk("reset flash", bus.flash, 0);
    chk("reset freeze", bus.freeze, 0);
    chk("reset game_over", bus.game_over, 0);
    chk("reset hit_pulse", bus.hit_pulse, 0);
    chk("reset respawn_req", bus.respawn_req, 0);

    // Table: sub-threshold frames, scoring, then hit+bottom in one frame.
    for (int i = 0; i < 7; i++) begin
      do_frame(tbl[i].nov, tbl[i].bot, ph, qh, pr, qr);
      chk($sformatf("vec%0d hit_pulse", i), ph, tbl[i].exp_hit);
      chk($sformatf("vec%0d hit_pulse_end", i), qh, 0);
      chk($sformatf("vec%0d lives", i), bus.lives, tbl[i].exp_lives);
      chk($sformatf("vec%0d score", i), bus.score, tbl[i].exp_score);
    end

    // FLASH: overlap and bottom every frame must be ignored.
    for (int k = 0; k < 60; k++) begin
      do_frame(10, 1'b1, ph, qh, pr, qr);
      chk($sformatf("flash%0d hit", k), ph, 0);
      chk($sformatf("flash%0d lives", k), bus.lives, 2);
      chk($sformatf("flash%0d score", k), bus.score, 5);
      if (k < 59) begin
        chk($sformatf("flash%0d flash", k), bus.flash, ((59 - k) >> 3) & 1);
        chk($sformatf("flash%0d respawn", k), pr, 0);
      end else begin
        chk("flash end flash", bus.flash, 0);
        chk("flash end respawn", pr, 1);
        chk("flash end respawn_end", qr, 0);
      end
    end

    // Back in PLAY: score up to saturation.
    for (int k = 0; k < 1018; k++) do_frame(0, 1'b1, ph, qh, pr, qr);
    chk("score at max", bus.score, 1023);
    do_frame(0, 1'b1, ph, qh, pr, qr);
    chk("score saturated", bus.score, 1023);

    // Second hit, FLASH, then fatal third hit.
    do_frame(4, 1'b0, ph, qh, pr, qr);
    chk("hit2 pulse", ph, 1);
    chk("hit2 lives", bus.lives, 1);
    for (int k = 0; k < 60; k++) do_frame(0, 1'b0, ph, qh, pr, qr);
    chk("hit2 respawn", pr, 1);
    do_frame(5, 1'b0, ph, qh, pr, qr);
    chk("hit3 pulse", ph, 1);
    chk("hit3 lives", bus.lives, 0);
    chk("hit3 game_over", bus.game_over, 1);
    chk("hit3 freeze", bus.freeze, 1);
    chk("hit3 score", bus.score, 1023);
    for (int k = 0; k < 2; k++) begin
      do_frame(10, 1'b1, ph, qh, pr, qr);
      chk($sformatf("over%0d hit", k), ph, 0);
      chk($sformatf("over%0d lives", k), bus.lives, 0);
      chk($sformatf("over%0d score", k), bus.score, 1023);
      chk($sformatf("over%0d game_over", k), bus.game_over, 1);
    end

    // Partial frame with 5 overlaps, then restart: count must be discarded.
    bus.blank_b = 1'b1;
    bus.rpixel = 1'b1; bus.apixel = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    bus.rpixel = 1'b0; bus.apixel = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("restart lives", bus.lives, 3);
    chk("restart score", bus.score, 0);
    chk("restart game_over", bus.game_over, 0);
    chk("restart freeze", bus.freeze, 0);
    do_frame(0, 1'b0, ph, qh, pr, qr);
    chk("restart no hit", ph, 0);
    chk("restart lives2", bus.lives, 3);

    // start in PLAY does nothing.
    bus.start = 1'b1;
    do_frame(0, 1'b1, ph, qh, pr, qr);
    bus.start = 1'b0;
    chk("start in play score", bus.score, 1);
    chk("start in play lives", bus.lives, 3);

    // Reset mid-FLASH (flash_cnt 30) with 7 overlap pixels pending.
    do_frame(4, 1'b0, ph, qh, pr, qr);
    chk("hit4 lives", bus.lives, 2);
    for (int k = 0; k < 29; k++) do_frame(0, 1'b0, ph, qh, pr, qr);
    chk("pre-reset flash", bus.flash, 1);
    bus.blank_b = 1'b1;
    bus.rpixel = 1'b1; bus.apixel = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    bus.rpixel = 1'b0; bus.apixel = 1'b0;
    reset = 1'b1;
    #2;
    chk("async reset lives", bus.lives, 3);
    chk("async reset score", bus.score, 0);
    chk("async reset flash", bus.flash, 0);
    chk("async reset freeze", bus.freeze, 0);
    chk("async reset game_over", bus.game_over, 0);
    tick(); tick();
    reset = 1'b0;
    tick();
    do_frame(0, 1'b0, ph, qh, pr, qr);
    chk("post-reset no hit", ph, 0);
    chk("post-reset lives", bus.lives, 3);
    chk("post-reset score", bus.score, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_collision_score
`default_nettype wire
